// File: rtl/i2c_pkg.sv
// Shared types and constants for the passive I2C bus tracker.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ACK   = 2'd2
  } i2c_state_t;

  localparam int unsigned I2C_BITS_PER_BYTE = 8;
  localparam logic        LINE_IDLE         = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser plus tick-gated persistence filter for one I2C line.
module i2c_line_filter
  import i2c_pkg::*;
#(
  parameter int unsigned FILT_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic line_in,
  output logic line_f
);

  localparam int unsigned CW = $clog2(FILT_LEN + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= LINE_IDLE;
      sync2  <= LINE_IDLE;
      line_f <= LINE_IDLE;
      cnt    <= '0;
    end else begin
      sync1 <= line_in;
      sync2 <= sync1;
      if (tick) begin
        if (sync2 == line_f) begin
          cnt <= '0;
        end else if (cnt == CW'(FILT_LEN - 1)) begin
          // FILT_LEN-th consecutive differing tick: accept the new level
          line_f <= sync2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/i2c_bus_tracker.sv
// Passive I2C front-end: filtered lines, START/STOP detection, byte+ACK assembly.
module i2c_bus_tracker
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned FILT_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_f,
  output logic       sda_f,
  output logic       start_det,
  output logic       stop_det,
  output logic       bus_busy,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       ack_bit,
  output logic       first_byte
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0] pcnt;
  logic          tick;

  assign tick = (pcnt == PW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pcnt <= '0;
    else if (tick) pcnt <= '0;
    else           pcnt <= pcnt + PW'(1);
  end

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk(clk), .rst(rst), .tick(tick), .line_in(scl_in), .line_f(scl_f)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk(clk), .rst(rst), .tick(tick), .line_in(sda_in), .line_f(sda_f)
  );

  logic scl_q;
  logic sda_q;
  logic scl_rise;
  logic start_ev;
  logic stop_ev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q <= LINE_IDLE;
      sda_q <= LINE_IDLE;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  // START/STOP need SCL high and steady; a simultaneous change counts only as an SCL edge
  assign scl_rise = scl_f & ~scl_q;
  assign start_ev = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_ev  = scl_f & scl_q & ~sda_q & sda_f;

  i2c_state_t state;
  i2c_state_t state_n;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic       pending;
  logic       do_start;
  logic       do_stop;
  logic       do_shift;
  logic       do_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    do_start = 1'b0;
    do_stop  = 1'b0;
    do_shift = 1'b0;
    do_byte  = 1'b0;
    if (start_ev) begin
      do_start = 1'b1;
      state_n  = SHIFT;
    end else if (stop_ev) begin
      do_stop = 1'b1;
      state_n = IDLE;
    end else if (scl_rise) begin
      case (state)
        IDLE:  state_n = IDLE;
        SHIFT: begin
          do_shift = 1'b1;
          if (bit_cnt == 4'(I2C_BITS_PER_BYTE - 1)) state_n = ACK;
        end
        ACK: begin
          do_byte = 1'b1;
          state_n = SHIFT;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_det  <= 1'b0;
      stop_det   <= 1'b0;
      byte_valid <= 1'b0;
      bus_busy   <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
      pending    <= 1'b0;
      byte_data  <= '0;
      ack_bit    <= 1'b1;
      first_byte <= 1'b0;
    end else begin
      start_det  <= do_start;
      stop_det   <= do_stop;
      byte_valid <= do_byte;
      if (do_start) begin
        bus_busy <= 1'b1;
        bit_cnt  <= '0;
        pending  <= 1'b1;
      end
      if (do_stop) begin
        bus_busy <= 1'b0;
        bit_cnt  <= '0;
      end
      if (do_shift) begin
        shreg   <= {shreg[6:0], sda_f};
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (do_byte) begin
        byte_data  <= shreg;
        ack_bit    <= sda_f;
        first_byte <= pending;
        pending    <= 1'b0;
        bit_cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_bus_tracker.sv
// Scoreboard bench: a slow filtered build and a CLK_DIV=1/FILT_LEN=1 build.
module tb_i2c_bus_tracker;

  typedef struct {
    logic [7:0] d;
    logic       a;
    logic       f;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_a = 1'b1, sda_a = 1'b1, scl_b = 1'b1, sda_b = 1'b1;

  logic       scl_f_a, sda_f_a, start_a, stop_a, busy_a, bv_a, ack_a, first_a;
  logic [7:0] data_a;
  logic       scl_f_b, sda_f_b, start_b, stop_b, busy_b, bv_b, ack_b, first_b;
  logic [7:0] data_b;

  int total = 0;
  int bad   = 0;
  int start_cnt_a = 0, stop_cnt_a = 0, byte_cnt_a = 0;
  int start_cnt_b = 0, stop_cnt_b = 0, byte_cnt_b = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];

  bit bsel = 1'b0;
  int ph   = 50;

  always #5 clk = ~clk;

  i2c_bus_tracker #(.CLK_DIV(4), .FILT_LEN(8)) dut_a (
    .clk(clk), .rst(rst), .scl_in(scl_a), .sda_in(sda_a),
    .scl_f(scl_f_a), .sda_f(sda_f_a), .start_det(start_a), .stop_det(stop_a),
    .bus_busy(busy_a), .byte_valid(bv_a), .byte_data(data_a),
    .ack_bit(ack_a), .first_byte(first_a)
  );

  i2c_bus_tracker #(.CLK_DIV(1), .FILT_LEN(1)) dut_b (
    .clk(clk), .rst(rst), .scl_in(scl_b), .sda_in(sda_b),
    .scl_f(scl_f_b), .sda_f(sda_f_b), .start_det(start_b), .stop_det(stop_b),
    .bus_busy(busy_b), .byte_valid(bv_b), .byte_data(data_b),
    .ack_bit(ack_b), .first_byte(first_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (start_a) start_cnt_a++;
    if (stop_a)  stop_cnt_a++;
    if (start_b) start_cnt_b++;
    if (stop_b)  stop_cnt_b++;
    if (bv_a) begin
      exp_t e;
      byte_cnt_a++;
      chk("a_byte_expected", 32'(sb_a.size() != 0), 1);
      if (sb_a.size() != 0) begin
        e = sb_a.pop_front();
        chk("a_byte_data", 32'(data_a), 32'(e.d));
        chk("a_ack_bit", 32'(ack_a), 32'(e.a));
        chk("a_first_byte", 32'(first_a), 32'(e.f));
      end
    end
    if (bv_b) begin
      exp_t e;
      byte_cnt_b++;
      chk("b_byte_expected", 32'(sb_b.size() != 0), 1);
      if (sb_b.size() != 0) begin
        e = sb_b.pop_front();
        chk("b_byte_data", 32'(data_b), 32'(e.d));
        chk("b_ack_bit", 32'(ack_b), 32'(e.a));
        chk("b_first_byte", 32'(first_b), 32'(e.f));
      end
    end
  end

  task automatic drive(input logic s, input logic d);
    if (bsel) begin scl_b = s; sda_b = d; end
    else      begin scl_a = s; sda_a = d; end
  endtask

  task automatic wait_ph();
    repeat (ph) @(negedge clk);
  endtask

  task automatic set_scl(input logic s);
    if (bsel) scl_b = s; else scl_a = s;
    wait_ph();
  endtask

  task automatic set_sda(input logic d);
    if (bsel) sda_b = d; else sda_a = d;
    wait_ph();
  endtask

  // Entered with SCL low (or bus idle); leaves SCL low
  task automatic send_start();
    set_sda(1'b1);
    set_scl(1'b1);
    set_sda(1'b0);
    set_scl(1'b0);
  endtask

  task automatic send_bit(input logic b);
    set_sda(b);
    set_scl(1'b1);
    set_scl(1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    send_bit(ack);
  endtask

  task automatic send_stop();
    set_sda(1'b0);
    set_scl(1'b1);
    set_sda(1'b1);
  endtask

  initial begin
    int   lat;
    logic any_low;

    repeat (3) @(negedge clk);
    chk("rst_scl_f", 32'(scl_f_a), 1);
    chk("rst_sda_f", 32'(sda_f_a), 1);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_byte_data", 32'(data_a), 0);
    chk("rst_ack_bit", 32'(ack_a), 1);
    chk("rst_first_byte", 32'(first_a), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Short SDA glitch with SCL high must be filtered out
    sda_a   = 1'b0;
    any_low = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!sda_f_a) any_low = 1'b1;
    end
    sda_a = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!sda_f_a) any_low = 1'b1;
    end
    chk("glitch_sda_f", 32'(any_low), 0);
    chk("glitch_no_start", 32'(start_cnt_a), 0);

    // Held low: accepted within 2 + FILT_LEN*CLK_DIV clocks -> START
    sda_a = 1'b0;
    lat   = 0;
    for (int k = 1; k <= ph; k++) begin
      @(negedge clk);
      if (lat == 0 && !sda_f_a) lat = k;
    end
    chk("start_latency_in_range", 32'(lat >= 31 && lat <= 34), 1);
    chk("start_once", 32'(start_cnt_a), 1);
    chk("busy_after_start", 32'(busy_a), 1);
    set_scl(1'b0);

    sb_a.push_back('{d: 8'hA0, a: 1'b0, f: 1'b1});
    send_byte(8'hA0, 1'b0);
    sb_a.push_back('{d: 8'h5A, a: 1'b1, f: 1'b0});
    send_byte(8'h5A, 1'b1);
    send_stop();
    chk("bytes_after_frame1", 32'(byte_cnt_a), 2);
    chk("stop_once", 32'(stop_cnt_a), 1);
    chk("busy_after_stop", 32'(busy_a), 0);

    // Repeated START discards a 3-bit partial byte
    send_start();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_start();
    sb_a.push_back('{d: 8'h3C, a: 1'b0, f: 1'b1});
    send_byte(8'h3C, 1'b0);
    send_stop();
    chk("starts_after_rs", 32'(start_cnt_a), 3);
    chk("bytes_after_rs", 32'(byte_cnt_a), 3);
    chk("stops_after_rs", 32'(stop_cnt_a), 2);

    // Async reset mid-byte, then SCL clocking without START
    send_start();
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_scl_f", 32'(scl_f_a), 1);
    chk("midrst_sda_f", 32'(sda_f_a), 1);
    chk("midrst_busy", 32'(busy_a), 0);
    chk("midrst_byte_data", 32'(data_a), 0);
    chk("midrst_ack_bit", 32'(ack_a), 1);
    scl_a = 1'b1;
    sda_a = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_ph();
    for (int i = 0; i < 9; i++) begin
      set_scl(1'b0);
      set_scl(1'b1);
    end
    chk("no_byte_without_start", 32'(byte_cnt_a), 3);
    chk("idle_busy", 32'(busy_a), 0);
    chk("idle_starts", 32'(start_cnt_a), 4);

    // Fast build: one clock per phase
    bsel = 1'b1;
    ph   = 1;
    repeat (5) @(negedge clk);
    sb_b.push_back('{d: 8'hFF, a: 1'b0, f: 1'b1});
    send_start();
    send_byte(8'hFF, 1'b0);
    send_stop();
    repeat (5) @(negedge clk);
    chk("b_start", 32'(start_cnt_b), 1);
    chk("b_stop", 32'(stop_cnt_b), 1);
    chk("b_bytes", 32'(byte_cnt_b), 1);
    chk("b_busy", 32'(busy_b), 0);

    drive(1'b0, 1'b0);
    repeat (5) @(negedge clk);
    drive(1'b1, 1'b1);
    repeat (5) @(negedge clk);
    chk("b_simul_no_start", 32'(start_cnt_b), 1);
    chk("b_simul_no_stop", 32'(stop_cnt_b), 1);
    chk("b_simul_busy", 32'(busy_b), 0);

    chk("a_scoreboard_drained", 32'(sb_a.size()), 0);
    chk("b_scoreboard_drained", 32'(sb_b.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
